// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, 3-sample majority vote, start-glitch
// rejection, parity/framing/overrun status and a valid/ready output handshake.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           hist_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d, pe_q, pe_d, fe_q, fe_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d, overrun_q, overrun_d;
    logic                 sample;

    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            hist_q    <= 3'b111;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            hist_q    <= {hist_q[1:0], rx_s_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            stop_q       <= 1'b0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stop_q       <= stop_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            pe_q         <= pe_d;
            fe_q         <= fe_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        stop_d       = stop_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        pe_d         = pe_q;
        fe_d         = fe_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;

        // Acceptance is applied first so a frame completing on the same edge still loads.
        if (valid_q && ready) begin
            valid_d      = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            overrun_d    = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                stop_d = 1'b0;
                par_d  = 1'b0;
                pe_d   = 1'b0;
                fe_d   = 1'b0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = sample;
                    par_d          = par_q ^ sample;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    pe_d    = (PARITY == 1) ? ~(par_q ^ sample) : (par_q ^ sample);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    fe_d  = fe_q | ~sample;
                    if (stop_q == STOP_LAST) begin
                        stop_d       = 1'b0;
                        data_d       = shreg_q;
                        frame_err_d  = fe_q | ~sample;
                        parity_err_d = pe_q;
                        overrun_d    = valid_q & ~ready;
                        valid_d      = 1'b1;
                        // A low final stop bit means the line may still be held low.
                        state_d      = sample ? S_IDLE : S_BRK;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            S_BRK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            stop_d  = 1'b0;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign busy       = state_q inside {S_START, S_DATA, S_PAR, S_STOP};
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E2 instance, driven from frame tables,
// random frames checked against a frame-level model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int NA = 16;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, rx_a, ready_a, en_b, rx_b, ready_b;
    logic [7:0] data_a, data_b;
    logic valid_a, busy_a, fe_a, pe_a, ov_a;
    logic valid_b, busy_b, fe_b, pe_b, ov_b;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic snap_pre, snap_busy, snap_valid;
    logic [7:0] snap_data;

    typedef struct { logic [7:0] d; logic pe; logic fe; logic ov; int cyc; } word_t;
    typedef struct { logic [7:0] d; logic pe; logic fe; int lat; } exp_t;
    typedef struct { int sel; logic [7:0] d; logic pbit; logic [1:0] stops;
                     logic [7:0] exp_d; logic exp_pe; logic exp_fe; } vec_t;

    word_t q_a[$];
    word_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(NA), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .rx(rx_a), .data(data_a), .valid(valid_a),
        .ready(ready_a), .busy(busy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

    uart_rx_param #(.CLKS_PER_BIT(NB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .rx(rx_b), .data(data_b), .valid(valid_b),
        .ready(ready_b), .busy(busy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

    // Words are logged just after the falling edge, with the ready that the next rising edge sees.
    always @(negedge clk) begin
        #1;
        if (valid_a && ready_a) q_a.push_back('{data_a, pe_a, fe_a, ov_a, cyc});
        if (valid_b && ready_b) q_b.push_back('{data_b, pe_b, fe_b, ov_b, cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_wire(input logic [7:0] d, input int pm, input logic pbit,
                                            input logic [1:0] stops, input int nstop);
        logic [15:0] w;
        int pos;
        w      = '1;
        w[0]   = 1'b0;
        w[8:1] = d;
        pos    = 9;
        if (pm != 0) begin
            w[9] = pbit;
            pos  = 10;
        end
        for (int s = 0; s < nstop; s++) w[pos + s] = stops[s];
        return w;
    endfunction

    function automatic exp_t model(input logic [15:0] w, input int pm, input int nstop, input int n);
        exp_t e;
        int ones;
        int m;
        e.d  = w[8:1];
        ones = $countones(w[8:1]);
        e.pe = 1'b0;
        if (pm != 0) begin
            ones = ones + int'(w[9]);
            e.pe = (pm == 1) ? (ones % 2 != 1) : (ones % 2 != 0);
        end
        e.fe = 1'b0;
        for (int s = 0; s < nstop; s++)
            if (w[9 + ((pm != 0) ? 1 : 0) + s] == 1'b0) e.fe = 1'b1;
        m     = 8 + ((pm != 0) ? 1 : 0) + nstop;
        e.lat = 3 + n / 2 + n * m;
        return e;
    endfunction

    task automatic send(input int sel, input logic [15:0] w, input int nbits, input int glitch_bit,
                        input int abort_kind, input int abort_bit, output int s_cyc);
        int n;
        logic v;
        n     = (sel == 0) ? NA : NB;
        s_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < n; c++) begin
                v = w[b];
                if (b == glitch_bit && c == n / 2 - 2) v = ~v;
                if (b == abort_bit && c == n / 2 + 1) begin
                    snap_busy  = busy_a;
                    snap_valid = valid_a;
                    snap_data  = data_a;
                end
                if (b == abort_bit && c == n / 2) begin
                    snap_pre = busy_a;
                    if (abort_kind == 1) en_a = 1'b0;
                    else if (abort_kind == 2) rst_n = 1'b0;
                end
                if (sel == 0) rx_a = v; else rx_b = v;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int sel, input int k);
        if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    task automatic accept_a();
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
    endtask

    task automatic expect_word(input int sel, input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input logic ov, input int at_cyc);
        word_t wd;
        int sz;
        sz = (sel == 0) ? q_a.size() : q_b.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_arrive: got no word, want data 0x%0h", tag, d);
        end else begin
            if (sel == 0) wd = q_a.pop_front(); else wd = q_b.pop_front();
            check({tag, "_data"}, 32'(wd.d), 32'(d));
            check({tag, "_perr"}, 32'(wd.pe), 32'(pe));
            check({tag, "_ferr"}, 32'(wd.fe), 32'(fe));
            check({tag, "_ovr"}, 32'(wd.ov), 32'(ov));
            if (at_cyc >= 0) check({tag, "_cycle"}, 32'(wd.cyc), 32'(at_cyc));
        end
    endtask

    vec_t vecs[10];
    logic [15:0] w;
    int s, nb, sel, pm, nstop, n, gap;
    exp_t m;
    logic busy_seen;

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h81, 1'b0, 2'b11, 8'h81, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h80, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
        vecs[7] = '{1, 8'hC3, 1'b0, 2'b11, 8'hC3, 1'b0, 1'b0};
        vecs[8] = '{1, 8'h5A, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b1};
        vecs[9] = '{1, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};

        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        snap_pre = 1'b0; snap_busy = 1'b0; snap_valid = 1'b0; snap_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);

        // Fixed frame table on both configurations.
        for (int i = 0; i < 10; i++) begin
            sel   = vecs[i].sel;
            pm    = (sel == 0) ? 0 : 2;
            nstop = (sel == 0) ? 1 : 2;
            n     = (sel == 0) ? NA : NB;
            w     = mk_wire(vecs[i].d, pm, vecs[i].pbit, vecs[i].stops, nstop);
            nb    = 9 + ((pm != 0) ? 1 : 0) + nstop;
            m     = model(w, pm, nstop, n);
            send(sel, w, nb, -1, 0, -1, s);
            idle(sel, 8);
            expect_word(sel, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe,
                        vecs[i].exp_fe, 1'b0, s + m.lat);
        end

        // Random frames with random gaps, including back-to-back.
        for (int k = 0; k < 30; k++) begin
            sel   = int'($urandom_range(0, 1));
            pm    = (sel == 0) ? 0 : 2;
            nstop = (sel == 0) ? 1 : 2;
            n     = (sel == 0) ? NA : NB;
            w     = mk_wire(8'($urandom), pm, 1'($urandom),
                            ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11, nstop);
            nb    = 9 + ((pm != 0) ? 1 : 0) + nstop;
            m     = model(w, pm, nstop, n);
            send(sel, w, nb, -1, 0, -1, s);
            gap   = w[nb - 1] ? int'($urandom_range(0, 3)) : int'($urandom_range(6, 9));
            idle(sel, gap);
            expect_word(sel, $sformatf("rnd%0d", k), m.d, m.pe, m.fe, 1'b0, s + m.lat);
        end
        idle(0, 4);
        idle(1, 4);

        // Short start glitch is rejected at the half-bit decision.
        s = cyc;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_busy_hi", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy_a), 32'd0);
        repeat (200) @(negedge clk);
        check("glitch_noword", 32'(q_a.size()), 32'd0);

        // One-cycle glitch in the middle of data bit 3 is voted out.
        w = mk_wire(8'hA5, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, 4, 0, -1, s);
        idle(0, 4);
        expect_word(0, "vote", 8'hA5, 1'b0, 1'b0, 1'b0, s + 155);

        // Low stop bit followed by a held-low line.
        w = mk_wire(8'h3C, 0, 1'b0, 2'b00, 1);
        send(0, w, 10, -1, 0, -1, s);
        busy_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy_a) busy_seen = 1'b1;
            @(negedge clk);
        end
        expect_word(0, "brk", 8'h3C, 1'b0, 1'b1, 1'b0, s + 155);
        check("brk_busy", 32'(busy_seen), 32'd0);
        check("brk_noword", 32'(q_a.size()), 32'd0);
        idle(0, 10);
        check("brk_noword2", 32'(q_a.size()), 32'd0);
        w = mk_wire(8'h5A, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        idle(0, 4);
        expect_word(0, "brk_next", 8'h5A, 1'b0, 1'b0, 1'b0, s + 155);

        // Overrun with ready held low.
        ready_a = 1'b0;
        w = mk_wire(8'h11, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        check("ovr_first_valid", 32'(valid_a), 32'd1);
        check("ovr_first_ov", 32'(ov_a), 32'd0);
        w = mk_wire(8'h22, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        idle(0, 2);
        check("ovr_valid", 32'(valid_a), 32'd1);
        check("ovr_data", 32'(data_a), 32'h22);
        check("ovr_flag", 32'(ov_a), 32'd1);
        accept_a();
        check("ovr_clr_valid", 32'(valid_a), 32'd0);
        check("ovr_clr_flag", 32'(ov_a), 32'd0);
        expect_word(0, "ovr_word", 8'h22, 1'b0, 1'b0, 1'b1, -1);

        // Ready arriving on the completion edge accepts the old word, no overrun.
        w = mk_wire(8'h11, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        idle(0, 2);
        w = mk_wire(8'h22, 0, 1'b0, 2'b11, 1);
        fork
            send(0, w, 10, -1, 0, -1, s);
            begin
                repeat (154) @(negedge clk);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        check("same_valid", 32'(valid_a), 32'd1);
        check("same_data", 32'(data_a), 32'h22);
        check("same_ov", 32'(ov_a), 32'd0);
        expect_word(0, "same_old", 8'h11, 1'b0, 1'b0, 1'b0, -1);
        accept_a();
        expect_word(0, "same_new", 8'h22, 1'b0, 1'b0, 1'b0, -1);

        // en dropped in data bit 4 while an earlier word is pending.
        w = mk_wire(8'h33, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        idle(0, 2);
        w = mk_wire(8'h44, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 1, 5, s);
        idle(0, 6);
        en_a = 1'b1;
        idle(0, 4);
        check("en_busy_before", 32'(snap_pre), 32'd1);
        check("en_busy_after", 32'(snap_busy), 32'd0);
        check("en_keep_valid", 32'(valid_a), 32'd1);
        check("en_keep_data", 32'(data_a), 32'h33);
        accept_a();
        idle(0, 2);
        expect_word(0, "en_word", 8'h33, 1'b0, 1'b0, 1'b0, -1);
        check("en_no_partial", 32'(q_a.size()), 32'd0);

        // Reset mid-frame clears the pending word and the partial one.
        w = mk_wire(8'h55, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 0, -1, s);
        idle(0, 2);
        check("rstm_pending", 32'(valid_a), 32'd1);
        w = mk_wire(8'h66, 0, 1'b0, 2'b11, 1);
        send(0, w, 10, -1, 2, 5, s);
        idle(0, 6);
        rst_n = 1'b1;
        idle(0, 4);
        check("rstm_busy_before", 32'(snap_pre), 32'd1);
        check("rstm_busy", 32'(snap_busy), 32'd0);
        check("rstm_valid", 32'(snap_valid), 32'd0);
        check("rstm_data", 32'(snap_data), 32'd0);
        ready_a = 1'b1;
        idle(0, 200);
        check("rstm_noword", 32'(q_a.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable in bit period, data width, parity mode and stop-bit count.
- Adds a two-flop input synchroniser, 3-sample majority voting, start-bit glitch rejection, parity/framing/overrun detection and a valid/ready output handshake.
- Sits between the RX pad and a consumer such as a FIFO or register bank, in the same clock domain as that consumer.

## Interface
- CLKS_PER_BIT, 16: clocks per UART bit (N); even, ≥ 8.
- DATA_BITS, 8: payload width, 5–9, LSB first on the wire.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  receiver enable; low aborts any frame in progress and holds IDLE.
- rx  in  1  serial line, asynchronous, idles high.
- data  out  DATA_BITS  received word; valid only while valid=1.
- valid  out  1  word available; held until accepted.
- ready  in  1  consumer accepts the word when valid&ready.
- busy  out  1  frame reception in progress, from start detect to the final stop sample.
- frame_err  out  1  status of the held word: a stop bit was sampled 0.
- parity_err  out  1  status of the held word: parity mismatch (always 0 when PARITY=0).
- overrun  out  1  status of the held word: it overwrote an unaccepted word.

## Operation
- Reset values: data=0, valid=0, busy=0, frame_err=0, parity_err=0, overrun=0, state IDLE, all counters 0, synchroniser flops 1.
- Input path:
  - rx passes through two flops, giving rx_s.
  - A 3-bit shift history of rx_s feeds the sampler; sample = majority of the last 3 rx_s values.
- Bit counter cnt: width clog2(N); cleared on every state entry and on every sample instant.
- States:
  - IDLE: when rx_s=0 and en=1, go to START with cnt=0 and busy=1.
  - START: at cnt=N/2−1, take the majority sample. If 0, go to DATA. If 1 (glitch), go to IDLE with busy=0 and no status change.
  - DATA: at each cnt=N−1, shift the sample into the word at bit index idx. After idx=DATA_BITS−1, go to PAR if PARITY≠0, otherwise to STOP.
  - PAR: at cnt=N−1, compare the sample with the expected parity.
    - Odd: XOR(data, p)=1.
    - Even: XOR(data, p)=0.
  - STOP: sample at cnt=N−1 for each stop bit. frame_err_next = OR of (stop sample == 0).
- After the last stop sample:
  - Load data and the status flags; set valid=1; busy=0.
  - Next state is IDLE if the last stop sample was 1, otherwise BRK.
- BRK: wait for rx_s=1 and then go to IDLE. This prevents a held-low line or break from being read as a start bit.
- Handshake:
  - valid&ready on an edge clears valid and all three status flags on that edge.
  - data holds its last value.
- Overrun:
  - Applies when a frame completes on an edge where valid=1 and ready=0.
  - data and flags are overwritten by the new word, and overrun=1 for the new word.
  - If ready=1 on that same edge, the old word counts as accepted, the new word loads, and overrun=0.
- en=0: synchronously forces IDLE and clears busy, cnt and idx. Does not affect valid, data or flags, so a pending word survives.
- rst_n low mid-frame: immediate return to reset values; the partial word is lost.

## Timing
- Let t0 be the edge on which the first synchroniser flop captures rx=0, and M = DATA_BITS + (PARITY≠0) + STOP_BITS.
- IDLE→START on edge t0+2.
- Start decision on edge t0+2+N/2.
- Post-start bit k (k=1..M) is sampled on edge t0+2+N/2+N·k.
- valid rises and busy falls on edge t0+2+N/2+N·M. For defaults this is t0+154.
- A new start can be detected 2 edges after the line falls, so a back-to-back frame starting at the stop-bit end is received.
- Zero-cycle ready response: the word is accepted on the first edge with valid&ready.

## Test plan
- Defaults, 8N1 byte 0xA5 with ready=1 → valid is a 1-cycle pulse on edge t0+154, data=0xA5, all flags 0.
- PARITY=2, byte 0x07 with parity bit 0 (wrong) → data=0x07, parity_err=1. Repeat with parity bit 1 → parity_err=0.
- Stop bit driven 0 for 0x3C, line held low 40 cycles → frame_err=1. busy stays 0 in BRK, and no second word arrives until the line has returned high and a real start occurs.
- A 3-cycle low glitch on rx → no valid and busy drops after N/2 cycles. Separately, a 1-cycle glitch inside data bit 3 → correct byte (majority vote).
- ready=0, two back-to-back frames 0x11 then 0x22 → after the second frame data=0x22 and overrun=1. Asserting ready for one cycle then clears valid and overrun.
- en dropped at data bit 4, or rst_n asserted mid-frame → busy=0 immediately and no word delivered. A previously held valid word survives en=0 but is cleared by rst_n.
